seq_restoring_divider: RTL and testbench



---
 rtl/seq_restoring_divider.sv | 153 +++++++++++++++
 tb/tb_seq_restoring_divider.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider
//
// Sequential unsigned restoring divider. One trial subtraction per clock,
// reusing a single WIDTH+1-bit subtractor, so a divide takes WIDTH cycles
// after it is accepted. A zero divisor is resolved in one cycle without
// iterating.
//
// Ports:
//   Clk        - clock, all state changes on the rising edge
//   Reset_n    - synchronous active-low reset, overrides everything
//   Start      - divide request, accepted only in IDLE or DONE
//   Dividend   - unsigned numerator, captured on an accepted Start
//   Divisor    - unsigned denominator, captured on an accepted Start
//   Busy       - high while iterating
//   Done       - one-cycle completion pulse; results valid from this cycle
//   Quotient   - registered quotient, held until next completion or reset
//   Remainder  - registered remainder, held until next completion or reset
//   DivByZero  - registered divide-by-zero flag, valid with Done
module seq_restoring_divider #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             DivByZero
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // Iteration state: partial remainder, shifting dividend/quotient, divisor.
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [CNT_W-1:0] cnt_reg;

    // Visible result registers.
    logic [WIDTH-1:0] quotient_reg;
    logic [WIDTH-1:0] remainder_reg;
    logic             dbz_reg;

    logic             accept;
    logic             last_step;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] r_shifted;
    logic [WIDTH-1:0] r_step;
    logic [WIDTH-1:0] q_step;

    // Start is honoured anywhere except mid-iteration.
    assign accept    = Start && (state_reg != ST_RUN);
    assign last_step = (cnt_reg == CNT_W'(WIDTH - 1));

    // One restoring step. The shifted partial remainder is {R[W-2:0], Q[W-1]};
    // R's MSB takes the place of the zero extension in the trial subtraction.
    // The partial remainder never exceeds the bits of dividend consumed so
    // far, so R's MSB is always zero before the shift and nothing is lost.
    assign r_shifted = {r_reg[WIDTH-2:0], q_reg[WIDTH-1]};
    assign trial     = {r_reg, q_reg[WIDTH-1]} - {1'b0, d_reg};
    assign r_step    = trial[WIDTH] ? r_shifted : trial[WIDTH-1:0];
    assign q_step    = {q_reg[WIDTH-2:0], ~trial[WIDTH]};

    // State register.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_next = (Divisor == '0) ? ST_DONE : ST_RUN;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_step) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath and result registers.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_reg         <= '0;
            q_reg         <= '0;
            d_reg         <= '0;
            cnt_reg       <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        if (Divisor == '0) begin
                            quotient_reg  <= '1;
                            remainder_reg <= Dividend;
                            dbz_reg       <= 1'b1;
                        end else begin
                            r_reg   <= '0;
                            q_reg   <= Dividend;
                            d_reg   <= Divisor;
                            cnt_reg <= '0;
                        end
                    end
                end
                ST_RUN: begin
                    r_reg   <= r_step;
                    q_reg   <= q_step;
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (last_step) begin
                        quotient_reg  <= q_step;
                        remainder_reg <= r_step;
                        dbz_reg       <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs: handshake decoded from state, results straight from registers.
    always_comb begin
        Busy      = (state_reg == ST_RUN);
        Done      = (state_reg == ST_DONE);
        Quotient  = quotient_reg;
        Remainder = remainder_reg;
        DivByZero = dbz_reg;
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider (WIDTH=4).
// Expected results are pushed to a scoreboard queue when a divide is issued
// and popped when the DUT pulses Done.
module tb_seq_restoring_divider;

    localparam int W = 4;

    logic         Clk = 1'b0;
    logic         Reset_n;
    logic         Start;
    logic [W-1:0] Dividend;
    logic [W-1:0] Divisor;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Quotient;
    logic [W-1:0] Remainder;
    logic         DivByZero;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } exp_t;

    exp_t sb_q[$];

    seq_restoring_divider #(.WIDTH(W), .CNT_W(3)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Start     (Start),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Busy      (Busy),
        .Done      (Done),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .DivByZero (DivByZero)
    );

    always #5 Clk = ~Clk;

    // Reference model for one divide.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        if (b == 0) begin
            e.q = '1;
            e.r = a;
            e.dbz = 1'b1;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Present a request at a falling edge, push its expectation, and return
    // at the falling edge of the cycle right after the accepting edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        Dividend = a;
        Divisor  = b;
        Start    = 1'b1;
        sb_q.push_back(model(a, b));
        @(negedge Clk);
        Start = 1'b0;
    endtask

    // Wait (bounded) for Done. lat is the index of the Done cycle counted from
    // the cycle after acceptance; busy_n counts Busy cycles before it.
    task automatic wait_done(output int lat, output int busy_n,
                             output bit both, output bit got);
        int i;
        lat = -1; busy_n = 0; both = 1'b0; got = 1'b0;
        i = 0;
        while (!got && i < 20) begin
            if (Busy && Done) both = 1'b1;
            if (Done) begin
                got = 1'b1;
                lat = i;
            end else begin
                if (Busy) busy_n++;
                @(negedge Clk);
                i++;
            end
        end
    endtask

    task automatic test_reset;
        Reset_n = 1'b0; Start = 1'b1; Dividend = 4'd13; Divisor = 4'd3;
        @(negedge Clk);
        @(negedge Clk);
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %0b want 0", Busy); end
        total++; if (Done !== 1'b0) begin bad++; $display("FAIL rst_done: got %0b want 0", Done); end
        total++; if (Quotient !== 4'd0) begin bad++; $display("FAIL rst_quot: got %0d want 0", Quotient); end
        total++; if (Remainder !== 4'd0) begin bad++; $display("FAIL rst_rem: got %0d want 0", Remainder); end
        total++; if (DivByZero !== 1'b0) begin bad++; $display("FAIL rst_dbz: got %0b want 0", DivByZero); end
        Reset_n = 1'b1; Start = 1'b0;
        @(negedge Clk);
        total++; if (Busy !== 1'b0 || Done !== 1'b0) begin bad++; $display("FAIL rst_no_accept: busy=%0b done=%0b want 0,0", Busy, Done); end
        $display("reset: outputs cleared, no acceptance");
    endtask

    task automatic test_basic;
        int lat, bn; bit both, got; exp_t e;
        issue(4'd13, 4'd3);
        wait_done(lat, bn, both, got);
        total++; if (!got) begin bad++; $display("FAIL basic_timeout: got no Done want Done"); end
        e = sb_q.pop_front();
        total++; if (Quotient !== e.q) begin bad++; $display("FAIL basic_quot: got %0d want %0d", Quotient, e.q); end
        total++; if (Remainder !== e.r) begin bad++; $display("FAIL basic_rem: got %0d want %0d", Remainder, e.r); end
        total++; if (DivByZero !== e.dbz) begin bad++; $display("FAIL basic_dbz: got %0b want %0b", DivByZero, e.dbz); end
        total++; if (lat != W) begin bad++; $display("FAIL basic_latency: got %0d want %0d", lat, W); end
        total++; if (bn != W) begin bad++; $display("FAIL basic_busy_cycles: got %0d want %0d", bn, W); end
        total++; if (both) begin bad++; $display("FAIL basic_busy_done: got 1 want 0"); end
        $display("basic: 13/3 -> q=%0d r=%0d lat=%0d", Quotient, Remainder, lat);
        @(negedge Clk);
        total++; if (Done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse: got %0b want 0", Done); end
        total++; if (Quotient !== 4'd4 || Remainder !== 4'd1) begin bad++; $display("FAIL basic_hold: got %0d,%0d want 4,1", Quotient, Remainder); end
    endtask

    task automatic test_spot;
        logic [W-1:0] tbl [3][4];
        int lat, bn; bit both, got; exp_t e;
        tbl[0] = '{4'd15, 4'd1, 4'd15, 4'd0};
        tbl[1] = '{4'd0,  4'd5, 4'd0,  4'd0};
        tbl[2] = '{4'd5,  4'd7, 4'd0,  4'd5};
        for (int i = 0; i < 3; i++) begin
            issue(tbl[i][0], tbl[i][1]);
            wait_done(lat, bn, both, got);
            e = sb_q.pop_front();
            total++;
            if (!got || Quotient !== tbl[i][2] || Remainder !== tbl[i][3]) begin
                bad++;
                $display("FAIL spot_%0d_%0d: got q=%0d r=%0d want q=%0d r=%0d", tbl[i][0], tbl[i][1], Quotient, Remainder, tbl[i][2], tbl[i][3]);
            end
            $display("spot: %0d/%0d -> q=%0d r=%0d", tbl[i][0], tbl[i][1], Quotient, Remainder);
        end
    endtask

    task automatic test_sweep;
        int lat, bn; bit both, got; exp_t e;
        int errs_before;
        errs_before = bad;
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                issue(W'(a), W'(b));
                wait_done(lat, bn, both, got);
                e = sb_q.pop_front();
                total++;
                if (!got || Quotient !== e.q || Remainder !== e.r || DivByZero !== e.dbz || lat != W || both) begin
                    bad++;
                    $display("FAIL sweep_%0d_%0d: got q=%0d r=%0d z=%0b lat=%0d want q=%0d r=%0d z=%0b lat=%0d", a, b, Quotient, Remainder, DivByZero, lat, e.q, e.r, e.dbz, W);
                end
                total++;
                if ((int'(Quotient) * b + int'(Remainder)) != a || int'(Remainder) >= b) begin
                    bad++;
                    $display("FAIL sweep_invariant_%0d_%0d: got q=%0d r=%0d want q*d+r=%0d r<%0d", a, b, Quotient, Remainder, a, b);
                end
            end
        end
        $display("sweep: 240 divides, %0d new failures", bad - errs_before);
    endtask

    task automatic test_div_zero;
        int lat, bn; bit both, got; exp_t e;
        issue(4'd7, 4'd0);
        wait_done(lat, bn, both, got);
        e = sb_q.pop_front();
        total++; if (!got || lat != 0) begin bad++; $display("FAIL dz_latency: got %0d want 0", lat); end
        total++; if (bn != 0) begin bad++; $display("FAIL dz_busy: got %0d want 0", bn); end
        total++; if (Quotient !== e.q) begin bad++; $display("FAIL dz_quot: got %0d want %0d", Quotient, e.q); end
        total++; if (Remainder !== e.r) begin bad++; $display("FAIL dz_rem: got %0d want %0d", Remainder, e.r); end
        total++; if (DivByZero !== 1'b1) begin bad++; $display("FAIL dz_flag: got %0b want 1", DivByZero); end
        $display("div_zero: 7/0 -> q=%0d r=%0d z=%0b", Quotient, Remainder, DivByZero);
        @(negedge Clk);
        total++; if (Done !== 1'b0 || Busy !== 1'b0) begin bad++; $display("FAIL dz_after: busy=%0b done=%0b want 0,0", Busy, Done); end
    endtask

    task automatic test_back_to_back;
        int lat, bn; bit both, got; exp_t e;
        Dividend = 4'd12; Divisor = 4'd5; Start = 1'b1;
        sb_q.push_back(model(4'd12, 4'd5));
        @(negedge Clk);
        // In RUN now: new request and operands must be ignored until Done.
        Dividend = 4'd9; Divisor = 4'd2; Start = 1'b1;
        sb_q.push_back(model(4'd9, 4'd2));
        wait_done(lat, bn, both, got);
        e = sb_q.pop_front();
        total++; if (!got || Quotient !== e.q || Remainder !== e.r) begin bad++; $display("FAIL b2b_first: got q=%0d r=%0d want q=%0d r=%0d", Quotient, Remainder, e.q, e.r); end
        total++; if (lat != W) begin bad++; $display("FAIL b2b_first_latency: got %0d want %0d", lat, W); end
        $display("b2b: 12/5 -> q=%0d r=%0d", Quotient, Remainder);
        // Start still high on the Done cycle: accepted back-to-back.
        @(negedge Clk);
        Start = 1'b0;
        total++; if (Busy !== 1'b1) begin bad++; $display("FAIL b2b_accept: got busy=%0b want 1", Busy); end
        wait_done(lat, bn, both, got);
        e = sb_q.pop_front();
        total++; if (!got || Quotient !== e.q || Remainder !== e.r) begin bad++; $display("FAIL b2b_second: got q=%0d r=%0d want q=%0d r=%0d", Quotient, Remainder, e.q, e.r); end
        total++; if (lat != W) begin bad++; $display("FAIL b2b_second_latency: got %0d want %0d", lat, W); end
        $display("b2b: 9/2 -> q=%0d r=%0d", Quotient, Remainder);
    endtask

    task automatic test_reset_abort;
        int lat, bn; bit both, got; exp_t e;
        int done_seen;
        @(negedge Clk);
        Dividend = 4'd15; Divisor = 4'd2; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b0;
        @(negedge Clk);
        total++; if (Busy !== 1'b0 || Done !== 1'b0) begin bad++; $display("FAIL abort_flags: busy=%0b done=%0b want 0,0", Busy, Done); end
        total++; if (Quotient !== 4'd0 || Remainder !== 4'd0 || DivByZero !== 1'b0) begin bad++; $display("FAIL abort_results: got q=%0d r=%0d z=%0b want 0,0,0", Quotient, Remainder, DivByZero); end
        Reset_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (Done) done_seen++;
            @(negedge Clk);
        end
        total++; if (done_seen != 0) begin bad++; $display("FAIL abort_no_done: got %0d Done cycles want 0", done_seen); end
        issue(4'd15, 4'd2);
        wait_done(lat, bn, both, got);
        e = sb_q.pop_front();
        total++; if (!got || Quotient !== e.q || Remainder !== e.r || lat != W) begin bad++; $display("FAIL abort_fresh: got q=%0d r=%0d lat=%0d want q=%0d r=%0d lat=%0d", Quotient, Remainder, lat, e.q, e.r, W); end
        $display("abort: fresh 15/2 -> q=%0d r=%0d", Quotient, Remainder);
    endtask

    initial begin
        Reset_n  = 1'b0;
        Start    = 1'b0;
        Dividend = '0;
        Divisor  = '0;
        test_reset();
        test_basic();
        test_spot();
        test_sweep();
        test_div_zero();
        test_back_to_back();
        test_reset_abort();
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover: got %0d entries want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
